// File: rtl/mux_sel_arbiter_if.sv
// Purpose: bundle of request, data, grant and mux-output signals shared between
//          two bit-serial requesters and the mux_sel_arbiter.
// Signals:
//   req0, req1 : requester wants the line           (master -> slave)
//   d0, d1     : data bit from each requester       (master -> slave)
//   lock       : hold current grant, MUX_ARB_LOCK_EN only (master -> slave)
//   gnt0, gnt1 : one-hot-or-zero registered grants  (slave -> master)
//   sel        : registered mux select, 1 = d0       (slave -> master)
//   y_q, y_vld : registered mux output and its valid (slave -> master)
// Optional feature macro: MUX_ARB_LOCK_EN
interface mux_sel_arbiter_if;
    logic req0;
    logic req1;
    logic d0;
    logic d1;
`ifdef MUX_ARB_LOCK_EN
    logic lock;
`endif
    logic gnt0;
    logic gnt1;
    logic sel;
    logic y_q;
    logic y_vld;

    modport master (
`ifdef MUX_ARB_LOCK_EN
        output lock,
`endif
        output req0, req1, d0, d1,
        input  gnt0, gnt1, sel, y_q, y_vld
    );

    modport slave (
`ifdef MUX_ARB_LOCK_EN
        input  lock,
`endif
        input  req0, req1, d0, d1,
        output gnt0, gnt1, sel, y_q, y_vld
    );
endinterface

// File: rtl/mux_sel_arbiter.sv
// Purpose: round-robin arbiter sharing one 2:1 mux (y = sel ? d0 : d1) between
//          two requesters, with a hold counter bounding each contended grant.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous reset, active low
//   bus   : mux_sel_arbiter_if.slave (req0/req1/d0/d1[/lock] in,
//           gnt0/gnt1/sel/y_q/y_vld out, all outputs registered)
// Optional feature macro: MUX_ARB_LOCK_EN adds bus.lock, which holds the current
//   grant (no fairness switch, hold counter frozen) while the owner still requests.
module mux_sel_arbiter #(
    parameter int unsigned HOLD_MAX = 4,
    parameter int unsigned CNT_W    = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mux_sel_arbiter_if.slave      bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             last_q;
    logic             last_d;
    logic             sel_d;
    logic             own_req;
    logic             oth_req;
    logic             hold_lock;

`ifdef MUX_ARB_LOCK_EN
    assign hold_lock = bus.lock;
`else
    assign hold_lock = 1'b0;
`endif

    // Next-state, hold counter, last-served and select decode
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        sel_d   = bus.sel;
        own_req = 1'b0;
        oth_req = 1'b0;

        case (state_q)
            GNT0: begin
                own_req = bus.req0;
                oth_req = bus.req1;
            end
            GNT1: begin
                own_req = bus.req1;
                oth_req = bus.req0;
            end
            default: begin
                // Tie goes to whoever was not served last
                if (bus.req0 && bus.req1) begin
                    state_d = last_q ? GNT0 : GNT1;
                end else if (bus.req0) begin
                    state_d = GNT0;
                end else if (bus.req1) begin
                    state_d = GNT1;
                end else begin
                    state_d = IDLE;
                end
            end
        endcase

        if (state_q != IDLE) begin
            if (!own_req) begin
                state_d = IDLE;
            end else if (oth_req && !hold_lock) begin
                if (cnt_q == HOLD_LAST) begin
                    state_d = (state_q == GNT0) ? GNT1 : GNT0;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        end

        // Fresh grant or switch: restart the hold window and record the new owner
        if ((state_d != state_q) && (state_d != IDLE)) begin
            cnt_d  = '0;
            last_d = (state_d == GNT1);
        end

        // Select follows the owner and holds through IDLE
        case (state_d)
            GNT0:    sel_d = 1'b1;
            GNT1:    sel_d = 1'b0;
            default: sel_d = bus.sel;
        endcase
    end

    // State, grant, select and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            last_q    <= 1'b1;
            bus.gnt0  <= 1'b0;
            bus.gnt1  <= 1'b0;
            bus.sel   <= 1'b0;
            bus.y_q   <= 1'b0;
            bus.y_vld <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            last_q    <= last_d;
            bus.gnt0  <= (state_d == GNT0);
            bus.gnt1  <= (state_d == GNT1);
            bus.sel   <= sel_d;
            bus.y_q   <= bus.sel ? bus.d0 : bus.d1;
            bus.y_vld <= bus.gnt0 | bus.gnt1;
        end
    end

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Purpose: self-checking bench for mux_sel_arbiter; a behavioural owner/run-length
//          model is compared against the DUT every cycle, with literal checks for
//          reset, tie-break, fairness switch, data path, release and solo hold.
module tb_mux_sel_arbiter;

    localparam int HOLD_MAX = 4;
    localparam int CNT_MAX  = 7;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    mux_sel_arbiter_if bus();

    mux_sel_arbiter #(.HOLD_MAX(4), .CNT_W(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: who owns the line, how long it has held it under
    // contention, who was served last, and the resulting mux output.
    int m_own;
    int m_run;
    int m_last;
    bit m_sel;
    bit m_y;
    bit m_v;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_own  = -1;
            m_run  = 0;
            m_last = 1;
            m_sel  = 0;
            m_y    = 0;
            m_v    = 0;
        end else begin
            bit r0, r1, mine, other;
            int nxt;
            r0 = bus.req0;
            r1 = bus.req1;
            m_y = m_sel ? bus.d0 : bus.d1;
            m_v = (m_own >= 0);
            if (m_own < 0) begin
                if (r0 && r1)  nxt = (m_last == 1) ? 0 : 1;
                else if (r0)   nxt = 0;
                else if (r1)   nxt = 1;
                else           nxt = -1;
            end else begin
                mine  = (m_own == 0) ? r0 : r1;
                other = (m_own == 0) ? r1 : r0;
                if (!mine) nxt = -1;
                else if (other && m_run == HOLD_MAX - 1) nxt = 1 - m_own;
                else begin
                    nxt = m_own;
                    if (other && m_run < CNT_MAX) m_run++;
                end
            end
            if (nxt >= 0 && nxt != m_own) begin
                m_run  = 0;
                m_last = nxt;
            end
            if (nxt == 0) m_sel = 1;
            else if (nxt == 1) m_sel = 0;
            m_own = nxt;
        end
    end

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        if (rst_n) begin
            chk("gnt0", bus.gnt0, m_own == 0);
            chk("gnt1", bus.gnt1, m_own == 1);
            chk("sel", bus.sel, m_sel);
            chk("y_q", bus.y_q, m_y);
            chk("y_vld", bus.y_vld, m_v);
            chk("onehot", bus.gnt0 & bus.gnt1, 1'b0);
        end
    end

    // Apply inputs for one cycle, then advance to just after the next edge
    task automatic cyc(input bit r0, input bit r1, input bit a, input bit b);
        bus.req0 = r0;
        bus.req1 = r1;
        bus.d0   = a;
        bus.d1   = b;
        @(posedge clk);
        #1;
    endtask

    logic [3:0] vec [0:15];
    int solo;

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        bus.d0   = 1'b0;
        bus.d1   = 1'b0;
`ifdef MUX_ARB_LOCK_EN
        bus.lock = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        chk("rst_gnt0", bus.gnt0, 1'b0);
        chk("rst_y_vld", bus.y_vld, 1'b0);
        rst_n = 1'b1;

        // Tie from reset: requester 0 first, then alternate every HOLD_MAX cycles
        cyc(1, 1, 0, 0);
        chk("tie_first_gnt0", bus.gnt0, 1'b1);
        repeat (3) cyc(1, 1, 0, 0);
        chk("tie_hold_gnt0", bus.gnt0, 1'b1);
        cyc(1, 1, 0, 0);
        chk("tie_switch_gnt1", bus.gnt1, 1'b1);
        chk("tie_switch_sel", bus.sel, 1'b0);
        repeat (4) cyc(1, 1, 0, 0);
        chk("tie_back_gnt0", bus.gnt0, 1'b1);

        // Asynchronous reset mid-grant
        #2 rst_n = 1'b0;
        #1;
        chk("arst_gnt0", bus.gnt0, 1'b0);
        chk("arst_gnt1", bus.gnt1, 1'b0);
        chk("arst_sel", bus.sel, 1'b0);
        chk("arst_y_q", bus.y_q, 1'b0);
        chk("arst_y_vld", bus.y_vld, 1'b0);
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Data path through requester 1
        cyc(0, 1, 0, 0);
        chk("data_gnt1", bus.gnt1, 1'b1);
        chk("data_sel", bus.sel, 1'b0);
        cyc(0, 1, 0, 1);
        chk("data_y0", bus.y_q, 1'b1);
        chk("data_vld", bus.y_vld, 1'b1);
        cyc(0, 1, 0, 0);
        chk("data_y1", bus.y_q, 1'b0);
        cyc(0, 1, 0, 1);
        chk("data_y2", bus.y_q, 1'b1);
        cyc(0, 1, 0, 1);
        chk("data_y3", bus.y_q, 1'b1);
        cyc(0, 0, 0, 0);
        chk("data_rel_gnt1", bus.gnt1, 1'b0);
        chk("data_rel_vld", bus.y_vld, 1'b1);

        // Release of requester 0: one trailing valid, select held in IDLE
        cyc(1, 0, 1, 0);
        cyc(1, 0, 1, 0);
        chk("rel_gnt0", bus.gnt0, 1'b1);
        cyc(0, 0, 1, 0);
        chk("rel_gnt0_off", bus.gnt0, 1'b0);
        chk("rel_last_vld", bus.y_vld, 1'b1);
        chk("rel_last_y", bus.y_q, 1'b1);
        chk("rel_sel_hold", bus.sel, 1'b1);
        cyc(0, 0, 0, 0);
        chk("rel_vld_off", bus.y_vld, 1'b0);
        chk("rel_sel_hold2", bus.sel, 1'b1);

        // Solo requester keeps the grant indefinitely
        solo = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(1, 0, i[0], 0);
            if (bus.gnt0) solo++;
        end
        checks++;
        if (solo != 20) begin
            failures++;
            $display("FAIL solo_hold: got %0d expected 20", solo);
        end
        cyc(0, 0, 0, 0);

        // Mixed directed vectors {req0, req1, d0, d1}, incl. drop while switch pending
        vec[0]  = 4'b1101; vec[1]  = 4'b1110; vec[2]  = 4'b1111; vec[3]  = 4'b1100;
        vec[4]  = 4'b0000; vec[5]  = 4'b1110; vec[6]  = 4'b0111; vec[7]  = 4'b0101;
        vec[8]  = 4'b1111; vec[9]  = 4'b1011; vec[10] = 4'b1110; vec[11] = 4'b1101;
        vec[12] = 4'b1110; vec[13] = 4'b1000; vec[14] = 4'b0100; vec[15] = 4'b0000;
        for (int i = 0; i < 16; i++) begin
            logic [3:0] v;
            v = vec[i];
            cyc(v[3], v[2], v[1], v[0]);
        end
        repeat (2) cyc(0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
